led_pattern_engine: RTL and testbench
=====================================

# led_pattern_engine

Parametrised LED pattern sequencer, next generation of the single-pattern LED shifter. On a request it runs one of four patterns (bounce, rotate-left, rotate-right, bar-fill) over a `WIDTH`-bit LED bank. Step period and pass count are programmable per request, with a busy flag and a one-cycle completion pulse. It sits behind the wishbone LED peripheral, which drives the request/config inputs and reads `o_busy`/`o_done`.

## Interface
- `WIDTH`, 8: LED count; legal range 2..32.
- `CW`, 16: step-period counter width.
- `PW`, 4: pass-count width.
- `i_clk` in 1: sole clock; all logic on rising edge.
- `i_reset` in 1: asynchronous, active-high reset.
- `i_request` in 1: start request, sampled only in IDLE.
- `i_mode` in 2: 0 BOUNCE, 1 ROT_LEFT, 2 ROT_RIGHT, 3 FILL; latched on accept.
- `i_period` in CW: clock cycles per step; 0 is treated as 1; latched on accept.
- `i_passes` in PW: passes to run; 0 is treated as 1; latched on accept.
- `o_busy` out 1: registered; high in RUN.
- `o_done` out 1: registered one-cycle pulse when a run completes normally.
- `o_led` out WIDTH: registered LED pattern.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - `o_led`=0x..01, `o_busy`=0.
  - `i_request`=1 latches mode, period P, passes N; clears the step and pass counters; goes to RUN.
- **RUN**
  - The period counter counts 0..P-1. At P-1 it wraps and one step is taken.
  - Position index `idx` is 0..WIDTH-1, `$clog2(WIDTH)` bits.
  - BOUNCE: `idx` goes 0→WIDTH-1→0; 2(WIDTH-1) steps per pass; `o_led`=1<<idx.
  - ROT_LEFT: `idx`+1, wrapping WIDTH-1→0; WIDTH steps per pass; one-hot.
  - ROT_RIGHT: `idx`-1, wrapping 0→WIDTH-1; WIDTH steps per pass; one-hot.
  - FILL: same `idx` walk as BOUNCE; `o_led`=(2<<idx)-1 (thermometer: 01,03,…,all-ones,…,01).
  - Every pass ends with `idx`=0 and `o_led`=0x01.
  - The step that completes pass N moves the block to DONE.
- **DONE**
  - Lasts one cycle: `o_done`=1, `o_busy`=0. Then IDLE.
- **Boundary rules**
  - `i_request` in RUN or DONE is ignored and not queued.
  - Input changes during RUN have no effect.
  - In BOUNCE/FILL the turn-around at WIDTH-1 takes no extra step.
- **Invariants**
  - `o_led` is never 0.
  - `o_led` is one-hot in modes 0–2.
  - `o_led` is a contiguous LSB-anchored thermometer in mode 3.
  - Step counter ≤ steps-per-pass−1; pass counter ≤ N−1.

## Timing
- **Reset** (asynchronous): state=IDLE, `o_led`=1, `o_busy`=0, `o_done`=0, all counters 0, effective immediately.
  - Mid-run reset aborts the run with no `o_done`.
- **Request latency:** `i_request` high at edge k sets `o_busy`=1 after edge k.
- **Step timing:** step s (s=1..) is visible on `o_led` after edge k+s·P.
- **Run length:** the final step lands at edge k+S·N·P, where S is steps per pass. After that edge `o_done`=1 and `o_busy`=0 for exactly one cycle.
- **Earliest restart:** a new request is accepted at edge k+S·N·P+2.
- **Width rules:** counters compare with `==`, with no overflow.
  - P and N are zero-extended, then clamped to ≥1.
  - S is computed at elaboration for both S values (2(WIDTH-1) and WIDTH).

## Structure
- Shared header `led_pattern_defs.vh`: mode encodings `MODE_BOUNCE`=0, `MODE_ROT_LEFT`=1, `MODE_ROT_RIGHT`=2, `MODE_FILL`=3, and state encodings IDLE/RUN/DONE. The wishbone wrapper includes the same header.
- Sub-module `led_step_timer`: period counter parametrised on CW, with inputs enable, P and clear, and a one-cycle step output.
- The FSM, position/direction logic and LED decode stay in `led_pattern_engine`.
- Formal properties live in an `ifdef FORMAL` block:
  - the invariants listed under Operation;
  - `o_busy`/`o_done` are never both high;
  - `o_done` is never high two cycles in a row.

## Test plan
- **BOUNCE** (WIDTH=8, P=1, N=1):
  - Expected `o_led`: 01,02,04,…,80,40,…,01 over 14 cycles.
  - `o_done` high exactly one cycle after the last step.
  - `o_busy` high for 14 cycles.
- **ROT_LEFT** (P=3, N=2):
  - Each step is held 3 cycles.
  - 80→01 wrap occurs.
  - `o_busy` high for 48 cycles.
  - One `o_done`.
- **ROT_RIGHT and FILL** (P=1):
  - ROT_RIGHT: 01,80,40,…,02,01.
  - FILL: 01,03,07,…,FF,7F,…,01.
  - All `o_led` values are checked against the invariants.
- **Ignored requests and zero clamps:**
  - A request with a different mode during RUN is ignored.
  - A request during the DONE cycle is ignored.
  - P=0 and N=0 run identically to P=1, N=1.
- **Reset mid-run:** assert `i_reset` mid-pass in BOUNCE.
  - `o_led`=01 and `o_busy`=0 without a clock edge.
  - No `o_done`.
  - The next request starts cleanly from `idx`=0.

Source files
------------

// File: rtl/led_pattern_engine_pkg.sv
// Shared mode and state encodings for the LED pattern engine and its bus wrapper.
package led_pattern_engine_pkg;

    typedef enum logic [1:0] {
        MODE_BOUNCE    = 2'd0,
        MODE_ROT_LEFT  = 2'd1,
        MODE_ROT_RIGHT = 2'd2,
        MODE_FILL      = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Bounce and fill share the same out-and-back index walk.
    function automatic logic is_walk(input mode_e m);
        return (m == MODE_BOUNCE) || (m == MODE_FILL);
    endfunction

endpackage

// File: rtl/led_step_timer.sv
// Step-period counter: counts 0..P-1 while enabled and pulses o_step on the wrap cycle.
module led_step_timer #(
    parameter int unsigned CW = 16
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_enable,
    input  logic          i_clear,
    input  logic [CW-1:0] i_period,
    output logic          o_step
);

    logic [CW-1:0] cnt_q, cnt_d;

    // i_period is already clamped to >= 1 by the caller.
    assign o_step = i_enable && (cnt_q == (i_period - CW'(1)));

    always_comb begin
        cnt_d = cnt_q;
        if (i_clear || o_step) begin
            cnt_d = '0;
        end else if (i_enable) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_pattern_engine.sv
// LED pattern sequencer: bounce, rotate-left, rotate-right and bar-fill over a WIDTH-bit bank.
module led_pattern_engine
    import led_pattern_engine_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CW    = 16,
    parameter int unsigned PW    = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_request,
    input  logic [1:0]       i_mode,
    input  logic [CW-1:0]    i_period,
    input  logic [PW-1:0]    i_passes,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_led
);

    localparam int unsigned IW     = $clog2(WIDTH);
    localparam int unsigned S_WALK = 2 * (WIDTH - 1);
    localparam int unsigned S_ROT  = WIDTH;
    localparam int unsigned SW     = $clog2(S_WALK + 1);
    localparam logic [SW-1:0] LAST_WALK = SW'(S_WALK - 1);
    localparam logic [SW-1:0] LAST_ROT  = SW'(S_ROT - 1);
    localparam logic [IW-1:0] IDX_TOP   = IW'(WIDTH - 1);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [CW-1:0]    period_q, period_d;
    logic [PW-1:0]    passes_q, passes_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [SW-1:0]    step_cnt_q, step_cnt_d;
    logic [PW-1:0]    pass_cnt_q, pass_cnt_d;
    logic [WIDTH-1:0] led_q, led_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             accept;
    logic             step;
    logic [SW-1:0]    last_step;
    logic [WIDTH:0]   fill_ext;

    assign accept    = (state_q == ST_IDLE) && i_request;
    assign last_step = is_walk(mode_q) ? LAST_WALK : LAST_ROT;

    led_step_timer #(.CW(CW)) u_timer (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_enable (state_q == ST_RUN),
        .i_clear  (accept),
        .i_period (period_q),
        .o_step   (step)
    );

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        period_d   = period_q;
        passes_d   = passes_q;
        idx_d      = idx_q;
        step_cnt_d = step_cnt_q;
        pass_cnt_d = pass_cnt_q;

        case (state_q)
            ST_IDLE: begin
                idx_d = '0;
                if (i_request) begin
                    mode_d     = mode_e'(i_mode);
                    period_d   = (i_period == '0) ? CW'(1) : i_period;
                    passes_d   = (i_passes == '0) ? PW'(1) : i_passes;
                    step_cnt_d = '0;
                    pass_cnt_d = '0;
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                if (step) begin
                    // Walk direction follows the step count: rising for the first WIDTH-1 steps.
                    case (mode_q)
                        MODE_ROT_LEFT:  idx_d = (idx_q == IDX_TOP) ? '0 : idx_q + IW'(1);
                        MODE_ROT_RIGHT: idx_d = (idx_q == '0) ? IDX_TOP : idx_q - IW'(1);
                        default:        idx_d = (step_cnt_q < SW'(WIDTH - 1)) ? idx_q + IW'(1)
                                                                              : idx_q - IW'(1);
                    endcase
                    if (step_cnt_q == last_step) begin
                        step_cnt_d = '0;
                        if (pass_cnt_q == (passes_q - PW'(1))) begin
                            state_d = ST_DONE;
                        end else begin
                            pass_cnt_d = pass_cnt_q + PW'(1);
                        end
                    end else begin
                        step_cnt_d = step_cnt_q + SW'(1);
                    end
                end
            end
            ST_DONE: begin
                idx_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                idx_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        busy_d   = (state_d == ST_RUN);
        done_d   = (state_d == ST_DONE);
        fill_ext = ((WIDTH + 1)'(2) << idx_d) - (WIDTH + 1)'(1);
        led_d    = (mode_d == MODE_FILL) ? fill_ext[WIDTH-1:0] : (WIDTH'(1) << idx_d);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_BOUNCE;
            period_q   <= CW'(1);
            passes_q   <= PW'(1);
            idx_q      <= '0;
            step_cnt_q <= '0;
            pass_cnt_q <= '0;
            led_q      <= WIDTH'(1);
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            period_q   <= period_d;
            passes_q   <= passes_d;
            idx_q      <= idx_d;
            step_cnt_q <= step_cnt_d;
            pass_cnt_q <= pass_cnt_d;
            led_q      <= led_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign o_busy = busy_q;
    assign o_done = done_q;
    assign o_led  = led_q;

`ifdef FORMAL
    a_led_nonzero: assert property (@(posedge i_clk) disable iff (i_reset) o_led != '0);
    a_onehot:      assert property (@(posedge i_clk) disable iff (i_reset)
                                    (mode_q != MODE_FILL) |-> $onehot(o_led));
    a_thermo:      assert property (@(posedge i_clk) disable iff (i_reset)
                                    (mode_q == MODE_FILL) |->
                                    (o_led[0] && ((o_led & (o_led + WIDTH'(1))) == '0)));
    a_counters:    assert property (@(posedge i_clk) disable iff (i_reset)
                                    (state_q == ST_RUN) |->
                                    ((step_cnt_q <= last_step) && (pass_cnt_q <= passes_q - PW'(1))));
    a_busy_done:   assert property (@(posedge i_clk) disable iff (i_reset) !(o_busy && o_done));
    a_done_pulse:  assert property (@(posedge i_clk) disable iff (i_reset) o_done |=> !o_done);
`endif

endmodule

// File: tb/tb_led_pattern_engine.sv
// Self-checking bench for led_pattern_engine: directed table plus randomized runs against a pattern model.
module tb_led_pattern_engine;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic         req;
    logic [1:0]   mode;
    logic [15:0]  period;
    logic [3:0]   passes;
    logic         busy;
    logic         done;
    logic [W-1:0] led;

    int unsigned tests = 0;
    int unsigned fails = 0;

    typedef struct {
        int unsigned mode;
        int unsigned p;
        int unsigned n;
        int unsigned noise;
        int unsigned probe_c;
        int unsigned probe_exp;
        int unsigned exp_busy;
    } vec_t;

    vec_t tbl[8];

    led_pattern_engine #(.WIDTH(W), .CW(16), .PW(4)) dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_request (req),
        .i_mode    (mode),
        .i_period  (period),
        .i_passes  (passes),
        .o_busy    (busy),
        .o_done    (done),
        .o_led     (led)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int unsigned steps_per_pass(input int unsigned m);
        return (m == 0 || m == 3) ? 2 * (W - 1) : W;
    endfunction

    function automatic int unsigned pos_at(input int unsigned m, input int unsigned s);
        int unsigned t;
        t = s % steps_per_pass(m);
        case (m)
            1:       return t;
            2:       return (W - t) % W;
            default: return (t <= W - 1) ? t : 2 * (W - 1) - t;
        endcase
    endfunction

    function automatic int unsigned led_of(input int unsigned m, input int unsigned pos);
        return (m == 3) ? ((1 << (pos + 1)) - 1) : (1 << pos);
    endfunction

    // noise: 0 quiet inputs, 1 directed stray requests (mid-run and on the DONE cycle), 2 random inputs.
    task automatic run_check(input int unsigned m, input int unsigned p, input int unsigned n,
                             input int unsigned noise, input int unsigned probe_c,
                             input int unsigned probe_exp, input int unsigned exp_busy);
        int unsigned pe, ne, t, exp_led, busy_cnt, done_cnt;
        logic        inv_ok;
        pe       = (p == 0) ? 1 : p;
        ne       = (n == 0) ? 1 : n;
        t        = steps_per_pass(m) * ne * pe;
        busy_cnt = 0;
        done_cnt = 0;
        @(negedge clk);
        req    = 1'b1;
        mode   = m[1:0];
        period = p[15:0];
        passes = n[3:0];
        @(negedge clk);
        for (int unsigned c = 0; c <= t + 2; c++) begin
            exp_led = (c < t) ? led_of(m, pos_at(m, c / pe)) : 1;
            check($sformatf("led m=%0d c=%0d", m, c), {24'd0, led}, exp_led);
            check($sformatf("busy m=%0d c=%0d", m, c), {31'd0, busy}, {31'd0, (c < t)});
            check($sformatf("done m=%0d c=%0d", m, c), {31'd0, done}, {31'd0, (c == t)});
            if (m == 3) inv_ok = led[0] && ((led & (led + 8'd1)) == 8'd0);
            else        inv_ok = $onehot(led);
            check($sformatf("invariant m=%0d c=%0d", m, c), {31'd0, inv_ok}, 32'd1);
            if (c == probe_c) check($sformatf("probe m=%0d c=%0d", m, c), {24'd0, led}, probe_exp);
            busy_cnt += busy;
            done_cnt += done;
            req = 1'b0;
            if (noise == 1 && (c == 2 || c == t)) begin
                req  = 1'b1;
                mode = 2'(m + 1);
                period = 16'd5;
            end else if (noise == 2 && c <= t) begin
                req    = 1'($urandom_range(0, 1));
                mode   = 2'($urandom);
                period = 16'($urandom);
                passes = 4'($urandom);
            end
            @(negedge clk);
        end
        check($sformatf("busy_cycles m=%0d", m), busy_cnt, exp_busy);
        check($sformatf("done_pulses m=%0d", m), done_cnt, 1);
    endtask

    initial begin
        int unsigned done_cnt;
        int unsigned rm, rp, rn;

        tbl[0] = '{0, 1, 1, 0, 7,  'h80, 14};
        tbl[1] = '{1, 3, 2, 0, 21, 'h80, 48};
        tbl[2] = '{1, 3, 2, 1, 24, 'h01, 48};
        tbl[3] = '{2, 1, 1, 0, 1,  'h80, 8};
        tbl[4] = '{3, 1, 1, 0, 7,  'hFF, 14};
        tbl[5] = '{3, 1, 1, 1, 9,  'h3F, 14};
        tbl[6] = '{0, 0, 0, 0, 3,  'h08, 14};
        tbl[7] = '{3, 2, 1, 0, 5,  'h07, 28};

        rst    = 1'b0;
        req    = 1'b0;
        mode   = 2'd0;
        period = 16'd1;
        passes = 4'd1;
        #2 rst = 1'b1;
        #1;
        check("reset led", {24'd0, led}, 32'h01);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_check(tbl[i].mode, tbl[i].p, tbl[i].n, tbl[i].noise,
                      tbl[i].probe_c, tbl[i].probe_exp, tbl[i].exp_busy);
        end

        // Mid-run reset in BOUNCE: outputs must drop immediately and no completion follows.
        @(negedge clk);
        req    = 1'b1;
        mode   = 2'd0;
        period = 16'd1;
        passes = 4'd1;
        @(negedge clk);
        req = 1'b0;
        repeat (4) @(negedge clk);
        check("midrun led before reset", {24'd0, led}, 32'h10);
        rst = 1'b1;
        #1;
        check("midrun reset led", {24'd0, led}, 32'h01);
        check("midrun reset busy", {31'd0, busy}, 32'd0);
        check("midrun reset done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            done_cnt += done;
        end
        check("midrun no done", done_cnt, 0);
        check("midrun idle busy", {31'd0, busy}, 32'd0);
        run_check(0, 1, 1, 0, 1, 'h02, 14);

        for (int i = 0; i < 15; i++) begin
            rm = $urandom_range(0, 3);
            rp = $urandom_range(0, 3);
            rn = $urandom_range(0, 3);
            run_check(rm, rp, rn, 2, 0, 'h01,
                      steps_per_pass(rm) * ((rn == 0) ? 1 : rn) * ((rp == 0) ? 1 : rp));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
